// File: rtl/snn_pkg.sv
// Shared types and constants for the spike post-collection path.
// Holds the collector FSM state encoding and the FIFO entry width helper.
package snn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } post_state_e;

  localparam int unsigned POST_WIDTH_DEF  = 32;
  localparam int unsigned ENTRY_WIDTH_DEF = 2 * POST_WIDTH_DEF;
  localparam int unsigned SPIKE_CNT_W     = 32;

  // A buffered spike carries {post address, post data}.
  function automatic int unsigned entry_width(input int unsigned post_width);
    return 2 * post_width;
  endfunction

endpackage

// File: rtl/post_fifo.sv
// Synchronous first-word-fall-through FIFO with full/empty flags.
// The head is a registered read with look-ahead so that the next entry is already present when pop retires the current one.
module post_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] head_reg;
  logic [AW:0]      wr_ptr_reg, wr_ptr_next;
  logic [AW:0]      rd_ptr_reg, rd_ptr_next;
  logic             pop_ok, push_ok;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) && (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
  assign pop_ok  = pop & ~empty;
  // A full FIFO still accepts a push when the head retires in the same cycle.
  assign push_ok = push & (~full | pop_ok);

  assign wr_ptr_next = wr_ptr_reg + {{AW{1'b0}}, push_ok};
  assign rd_ptr_next = rd_ptr_reg + {{AW{1'b0}}, pop_ok};
  assign head        = head_reg;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      head_reg   <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      // Bypass covers the slot being written while it becomes the head.
      if (push_ok && (wr_ptr_reg[AW-1:0] == rd_ptr_next[AW-1:0])) begin
        head_reg <= push_data;
      end else begin
        head_reg <= mem[rd_ptr_next[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/post_collector.sv
// Round-robin collector of cluster spike posts into a buffered spike-memory write port.
// Optional POST_COLLECTOR_STATS_EN adds a saturating spike_count output.
module post_collector
  import snn_pkg::*;
#(
  parameter int NUM_CL     = 4,
  parameter int POST_WIDTH = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CL-1:0]            post_req,
  input  logic [NUM_CL*POST_WIDTH-1:0] post_waddr,
  input  logic [NUM_CL*POST_WIDTH-1:0] post_wdata,
  output logic [NUM_CL-1:0]            post_grant,
  output logic [POST_WIDTH-1:0]        post_addr,
  input  logic [POST_WIDTH-1:0]        base_addr,
  input  logic                         clear,
  output logic                         spk_wen,
  output logic [POST_WIDTH-1:0]        spk_waddr,
  output logic [POST_WIDTH-1:0]        spk_wdata,
  input  logic                         spk_ready,
  output logic                         overflow
`ifdef POST_COLLECTOR_STATS_EN
  ,
  output logic [SPIKE_CNT_W-1:0]       spike_count
`endif
);

  localparam int IDX_W   = (NUM_CL > 1) ? $clog2(NUM_CL) : 1;
  localparam int ENTRY_W = int'(entry_width(POST_WIDTH));

  post_state_e             state_reg, state_next;
  logic [NUM_CL-1:0]       grant_reg, grant_next;
  logic [IDX_W-1:0]        rr_ptr_reg, rr_ptr_next;
  logic [IDX_W-1:0]        sel_reg, sel_next;
  logic [POST_WIDTH-1:0]   post_addr_reg;
  logic                    overflow_reg;
  logic [IDX_W-1:0]        pick_idx;
  logic                    pick_valid;
  logic                    push, set_ovf;
  logic                    fifo_full, fifo_empty, fifo_pop;
  logic [ENTRY_W-1:0]      fifo_head;
  logic [POST_WIDTH-1:0]   waddr_arr [NUM_CL];
  logic [POST_WIDTH-1:0]   wdata_arr [NUM_CL];

  for (genvar gi = 0; gi < NUM_CL; gi++) begin : g_unpack
    assign waddr_arr[gi] = post_waddr[gi*POST_WIDTH +: POST_WIDTH];
    assign wdata_arr[gi] = post_wdata[gi*POST_WIDTH +: POST_WIDTH];
  end

  // First requester at or after the priority pointer, wrapping around.
  always_comb begin
    int idx;
    idx        = 0;
    pick_idx   = '0;
    pick_valid = 1'b0;
    for (int k = 0; k < NUM_CL; k++) begin
      idx = (int'(rr_ptr_reg) + k) % NUM_CL;
      if (!pick_valid && post_req[idx]) begin
        pick_valid = 1'b1;
        pick_idx   = IDX_W'(idx);
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    grant_next  = '0;
    rr_ptr_next = rr_ptr_reg;
    sel_next    = sel_reg;
    push        = 1'b0;
    set_ovf     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          if (fifo_full) begin
            state_next = HOLD;
            set_ovf    = 1'b1;
          end else begin
            state_next           = GRANT;
            grant_next[pick_idx] = 1'b1;
            sel_next             = pick_idx;
            rr_ptr_next          = (int'(pick_idx) == NUM_CL - 1) ? '0 : pick_idx + 1'b1;
          end
        end
      end
      GRANT: begin
        push       = 1'b1;
        state_next = IDLE;
      end
      HOLD: begin
        if (!fifo_full) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      grant_reg     <= '0;
      rr_ptr_reg    <= '0;
      sel_reg       <= '0;
      post_addr_reg <= '0;
      overflow_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      grant_reg  <= grant_next;
      rr_ptr_reg <= rr_ptr_next;
      sel_reg    <= sel_next;
      if (clear) begin
        post_addr_reg <= push ? base_addr + 1'b1 : base_addr;
      end else if (push) begin
        post_addr_reg <= post_addr_reg + 1'b1;
      end
      if (clear) begin
        overflow_reg <= 1'b0;
      end else if (set_ovf) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  assign fifo_pop = ~fifo_empty & spk_ready;

  post_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({waddr_arr[sel_reg], wdata_arr[sel_reg]}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign post_grant = grant_reg;
  assign post_addr  = post_addr_reg;
  assign overflow   = overflow_reg;
  assign spk_wen    = ~fifo_empty;
  // Masked so stale RAM contents never appear on the write port while idle.
  assign spk_waddr  = spk_wen ? fifo_head[ENTRY_W-1:POST_WIDTH] : '0;
  assign spk_wdata  = spk_wen ? fifo_head[POST_WIDTH-1:0] : '0;

`ifdef POST_COLLECTOR_STATS_EN
  logic [SPIKE_CNT_W-1:0] spike_count_reg;
  logic                   push_accepted;

  assign push_accepted = push & (~fifo_full | fifo_pop);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      spike_count_reg <= '0;
    end else if (push_accepted && (spike_count_reg != '1)) begin
      spike_count_reg <= spike_count_reg + 1'b1;
    end
  end

  assign spike_count = spike_count_reg;
`endif

endmodule

// File: tb/tb_post_collector.sv
// Directed self-checking bench for post_collector (default parameters).
// Checks of spike_count are compiled in only with POST_COLLECTOR_STATS_EN.
module tb_post_collector;
  import snn_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   post_req;
  logic [127:0] post_waddr;
  logic [127:0] post_wdata;
  logic [3:0]   post_grant;
  logic [31:0]  post_addr;
  logic [31:0]  base_addr;
  logic         clear;
  logic         spk_wen;
  logic [31:0]  spk_waddr;
  logic [31:0]  spk_wdata;
  logic         spk_ready;
  logic         overflow;
`ifdef POST_COLLECTOR_STATS_EN
  logic [31:0]  spike_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  post_collector dut (
    .clk        (clk),
    .rst        (rst),
    .post_req   (post_req),
    .post_waddr (post_waddr),
    .post_wdata (post_wdata),
    .post_grant (post_grant),
    .post_addr  (post_addr),
    .base_addr  (base_addr),
    .clear      (clear),
    .spk_wen    (spk_wen),
    .spk_waddr  (spk_waddr),
    .spk_wdata  (spk_wdata),
    .spk_ready  (spk_ready),
    .overflow   (overflow)
`ifdef POST_COLLECTOR_STATS_EN
    ,
    .spike_count(spike_count)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; clear = 1'b0; post_req = '0; base_addr = '0; spk_ready = 1'b1;
    post_waddr = '0; post_wdata = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic wait_grant(input string name);
    bit found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (post_grant != 4'b0000) found = 1;
      else tick();
    end
    if (!found) begin
      n_checks++; n_fail++;
      $display("FAIL %s_timeout: got no grant in 20 cycles, required a grant", name);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (post_grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b required 0000", post_grant); end
    n_checks++; if (spk_wen !== 1'b0) begin n_fail++; $display("FAIL reset_wen: got %b required 0", spk_wen); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b required 0", overflow); end
    n_checks++; if (post_addr !== 32'h0) begin n_fail++; $display("FAIL reset_post_addr: got %h required 0", post_addr); end
`ifdef POST_COLLECTOR_STATS_EN
    n_checks++; if (spike_count !== 32'h0) begin n_fail++; $display("FAIL reset_spike_count: got %0d required 0", spike_count); end
`endif
  endtask

  task automatic test_single();
    do_reset();
    base_addr = 32'h100; clear = 1'b1;
    tick();
    clear = 1'b0;
    post_waddr[31:0] = 32'h10; post_wdata[31:0] = 32'h5; post_req = 4'b0001;
    tick();
    $display("single: grant=%b post_addr=%h", post_grant, post_addr);
    n_checks++; if (post_grant !== 4'b0001) begin n_fail++; $display("FAIL single_grant: got %b required 0001", post_grant); end
    n_checks++; if (post_addr !== 32'h100) begin n_fail++; $display("FAIL single_addr0: got %h required 100", post_addr); end
    post_req = 4'b0000;
    tick();
    $display("single: wen=%b waddr=%h wdata=%h", spk_wen, spk_waddr, spk_wdata);
    n_checks++; if (post_grant !== 4'b0000) begin n_fail++; $display("FAIL single_grant_drop: got %b required 0000", post_grant); end
    n_checks++; if (post_addr !== 32'h101) begin n_fail++; $display("FAIL single_addr1: got %h required 101", post_addr); end
    n_checks++; if ({spk_wen, spk_waddr, spk_wdata} !== {1'b1, 32'h10, 32'h5})
      begin n_fail++; $display("FAIL single_write: got %b/%h/%h required 1/10/5", spk_wen, spk_waddr, spk_wdata); end
    tick();
    n_checks++; if (spk_wen !== 1'b0) begin n_fail++; $display("FAIL single_popped: got %b required 0", spk_wen); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    do_reset();
    for (int n = 0; n < 4; n++) begin
      post_waddr[n*32 +: 32] = 32'h10 + n;
      post_wdata[n*32 +: 32] = 32'h20 + n;
    end
    post_req = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      $display("rr %0d: grant=%b", k, post_grant);
      n_checks++; if (post_grant !== exp_g) begin n_fail++; $display("FAIL rr_grant%0d: got %b required %b", k, post_grant, exp_g); end
      tick();
      n_checks++; if (post_grant !== 4'b0000) begin n_fail++; $display("FAIL rr_gap%0d: got %b required 0000", k, post_grant); end
      n_checks++; if (spk_waddr !== 32'h10 + (k % 4)) begin n_fail++; $display("FAIL rr_waddr%0d: got %h required %h", k, spk_waddr, 32'h10 + (k % 4)); end
      tick();
    end
    post_req = 4'b0000;
  endtask

  task automatic test_overflow_drain();
    int nw = 0;
    int ng = 0;
    do_reset();
    spk_ready = 1'b0; post_req = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      post_waddr[31:0] = 32'h40 + i; post_wdata[31:0] = i;
      wait_grant("fill");
      tick();
    end
    post_waddr[31:0] = 32'h48; post_wdata[31:0] = 32'd8;
    tick();
    tick();
    $display("overflow: state=%0d overflow=%b post_addr=%h", dut.state_reg, overflow, post_addr);
    n_checks++; if (dut.state_reg !== HOLD) begin n_fail++; $display("FAIL ovf_state: got %0d required %0d", dut.state_reg, HOLD); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b required 1", overflow); end
    n_checks++; if (post_grant !== 4'b0000) begin n_fail++; $display("FAIL ovf_no_grant: got %b required 0000", post_grant); end
    n_checks++; if (post_addr !== 32'h8) begin n_fail++; $display("FAIL ovf_post_addr: got %h required 8", post_addr); end
    spk_ready = 1'b1;
    for (int c = 0; c < 40 && nw < 9; c++) begin
      if (spk_wen) begin
        $display("drain write %0d: waddr=%h wdata=%h", nw, spk_waddr, spk_wdata);
        n_checks++; if ({spk_waddr, spk_wdata} !== {32'h40 + nw, 32'(nw)})
          begin n_fail++; $display("FAIL drain_order%0d: got %h/%h required %h/%h", nw, spk_waddr, spk_wdata, 32'h40 + nw, nw); end
        nw++;
      end
      if (post_grant != 4'b0000) begin ng++; post_req = 4'b0000; end
      tick();
    end
    n_checks++; if (nw !== 9) begin n_fail++; $display("FAIL drain_count: got %0d required 9", nw); end
    n_checks++; if (ng !== 1) begin n_fail++; $display("FAIL drain_grants: got %0d required 1", ng); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b required 1", overflow); end
`ifdef POST_COLLECTOR_STATS_EN
    n_checks++; if (spike_count !== 32'd9) begin n_fail++; $display("FAIL spike_count9: got %0d required 9", spike_count); end
`endif
  endtask

  task automatic test_clear_grant();
    base_addr = 32'h200;
    post_waddr[31:0] = 32'h77; post_wdata[31:0] = 32'h33; post_req = 4'b0001;
    wait_grant("clr");
    clear = 1'b1;
    tick();
    clear = 1'b0; post_req = 4'b0000;
    $display("clear+grant: post_addr=%h overflow=%b wen=%b waddr=%h", post_addr, overflow, spk_wen, spk_waddr);
    n_checks++; if (post_addr !== 32'h201) begin n_fail++; $display("FAIL clr_post_addr: got %h required 201", post_addr); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL clr_overflow: got %b required 0", overflow); end
    n_checks++; if ({spk_wen, spk_waddr, spk_wdata} !== {1'b1, 32'h77, 32'h33})
      begin n_fail++; $display("FAIL clr_pushed: got %b/%h/%h required 1/77/33", spk_wen, spk_waddr, spk_wdata); end
    tick();
  endtask

  task automatic test_rst_grant();
    do_reset();
    spk_ready = 1'b0; post_req = 4'b0001;
    post_waddr[31:0] = 32'h55; post_wdata[31:0] = 32'h66;
    for (int i = 0; i < 2; i++) begin
      wait_grant("prefill");
      tick();
    end
    wait_grant("rst");
    rst = 1'b1;
    tick();
    $display("rst in grant: grant=%b wen=%b addr=%h ovf=%b state=%0d", post_grant, spk_wen, post_addr, overflow, dut.state_reg);
    n_checks++; if ({post_grant, spk_wen, overflow} !== 6'b0) begin n_fail++; $display("FAIL rst_ctrl: got %b required 000000", {post_grant, spk_wen, overflow}); end
    n_checks++; if ({post_addr, spk_waddr, spk_wdata} !== 96'h0) begin n_fail++; $display("FAIL rst_data: got %h required 0", {post_addr, spk_waddr, spk_wdata}); end
    n_checks++; if (dut.state_reg !== IDLE) begin n_fail++; $display("FAIL rst_state: got %0d required %0d", dut.state_reg, IDLE); end
    rst = 1'b0; post_req = 4'b0000;
    tick();
    n_checks++; if (spk_wen !== 1'b0) begin n_fail++; $display("FAIL rst_discard: got %b required 0", spk_wen); end
  endtask

  task automatic test_wrap();
    do_reset();
    base_addr = 32'hFFFF_FFFF; clear = 1'b1;
    tick();
    clear = 1'b0; post_req = 4'b0010;
    wait_grant("wrap");
    n_checks++; if (post_addr !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_before: got %h required ffffffff", post_addr); end
    post_req = 4'b0000;
    tick();
    $display("wrap: post_addr=%h", post_addr);
    n_checks++; if (post_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_after: got %h required 0", post_addr); end
`ifdef POST_COLLECTOR_STATS_EN
    n_checks++; if (spike_count !== 32'd1) begin n_fail++; $display("FAIL stats_one: got %0d required 1", spike_count); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_checks++; if (spike_count !== 32'd0) begin n_fail++; $display("FAIL stats_clear: got %0d required 0", spike_count); end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_overflow_drain();
    test_clear_grant();
    test_rst_grant();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
